// File: rtl/hyperram_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its neighbours: the DVP capture
// FIFO, the HyperRAM memory-op engine, the debug UART TX and the status lines.
interface hyperram_frame_sequencer_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 23,
   parameter int SLOT_W = 1
);
   logic              iEn;
   logic              oFifoRdEn;
   logic [DATA_W-1:0] iFifoData;
   logic              iFifoEmpty;
   logic              iFrmDone;
   logic [31:0]       iFrmBytes;
   logic              oOpEn;
   logic [2:0]        oOpReq;
   logic [ADDR_W-1:0] oOpAddr;
   logic [DATA_W-1:0] oOpData;
   logic [DATA_W-1:0] iOpRdData;
   logic              iOpDone;
   logic              oTxEn;
   logic [7:0]        oTxData;
   logic              iTxDone;
   logic [SLOT_W-1:0] oSlot;
   logic [15:0]       oFrmCnt;
   logic              oOverflow;
   logic              oUploadDone;

   // Sequencer side
   modport master (
      input  iEn, iFifoData, iFifoEmpty, iFrmDone, iFrmBytes,
             iOpRdData, iOpDone, iTxDone,
      output oFifoRdEn, oOpEn, oOpReq, oOpAddr, oOpData,
             oTxEn, oTxData, oSlot, oFrmCnt, oOverflow, oUploadDone
   );

   // Environment side (FIFO, op engine, UART, status consumer)
   modport slave (
      output iEn, iFifoData, iFifoEmpty, iFrmDone, iFrmBytes,
             iOpRdData, iOpDone, iTxDone,
      input  oFifoRdEn, oOpEn, oOpReq, oOpAddr, oOpData,
             oTxEn, oTxData, oSlot, oFrmCnt, oOverflow, oUploadDone
   );
endinterface

// File: rtl/hyperram_frame_sequencer.sv
// Multi-slot HyperRAM frame sequencer. Drains an FWFT camera FIFO into a ring
// of frame slots through the memory-op engine and, when UPLOAD_EN is set,
// reads each closed frame back and streams it MSB-first to the debug UART.
module hyperram_frame_sequencer #(
   parameter int DATA_W      = 128,
   parameter int WORD_W      = 16,
   parameter int ADDR_W      = 23,
   parameter int FRAME_SLOTS = 2,
   parameter int SLOT_WORDS  = 2097152,
   parameter int UPLOAD_EN   = 1
) (
   input  logic                        iClk,
   input  logic                        iRst,
   hyperram_frame_sequencer_if.master  bus
);

   localparam int          SLOT_W        = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
   localparam int          BEAT_WORDS    = DATA_W / WORD_W;
   localparam int          BEAT_BYTES    = DATA_W / 8;
   localparam logic [31:0] BEAT_WORDS_32 = 32'(BEAT_WORDS);
   localparam logic [31:0] SLOT_WORDS_32 = 32'(SLOT_WORDS);
   localparam logic [31:0] SLOT_BYTES    = 32'((longint'(SLOT_WORDS) * WORD_W) / 8);
   localparam logic [15:0] BEAT_BYTES_16 = 16'(BEAT_BYTES);
   localparam logic [2:0]  OP_WR         = 3'b100;
   localparam logic [2:0]  OP_RD         = 3'b011;

   typedef enum logic [2:0] {
      IDLE, FETCH, WRITE, DISCARD, CLOSE, READ, TX, TX_GAP
   } state_t;

   state_t              state;
   logic [SLOT_W-1:0]   slot;
   logic                frm_pend;
   logic [31:0]         wr_off;
   logic [31:0]         rd_off;
   logic [31:0]         byte_cnt;
   logic [31:0]         frm_bytes;
   logic [15:0]         beat_byte;
   logic [DATA_W-1:0]   shreg;

   logic                fifo_rd_en;
   logic                op_en;
   logic [2:0]          op_req;
   logic [ADDR_W-1:0]   op_addr;
   logic [DATA_W-1:0]   op_data;
   logic                tx_en;
   logic [7:0]          tx_data;
   logic [15:0]         frm_cnt;
   logic                overflow;
   logic                upload_done;

   logic [ADDR_W-1:0]   slot_base;
   logic [31:0]         close_bytes;

   // Frame byte count clamped to what a slot can actually hold.
   function automatic logic [31:0] clamp_bytes(input logic [31:0] b);
      return (b > SLOT_BYTES) ? SLOT_BYTES : b;
   endfunction

   // Ring-buffer successor of a slot index.
   function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
      return (s == SLOT_W'(FRAME_SLOTS - 1)) ? '0 : s + 1'b1;
   endfunction

   assign slot_base   = ADDR_W'(slot) * ADDR_W'(SLOT_WORDS);
   assign close_bytes = clamp_bytes(bus.iFrmBytes);

   // Sequencer FSM with registered outputs; frame-done latch rides along.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state       <= IDLE;
         slot        <= '0;
         frm_pend    <= 1'b0;
         wr_off      <= '0;
         rd_off      <= '0;
         byte_cnt    <= '0;
         frm_bytes   <= '0;
         beat_byte   <= '0;
         shreg       <= '0;
         fifo_rd_en  <= 1'b0;
         op_en       <= 1'b0;
         op_req      <= '0;
         op_addr     <= '0;
         op_data     <= '0;
         tx_en       <= 1'b0;
         tx_data     <= '0;
         frm_cnt     <= '0;
         overflow    <= 1'b0;
         upload_done <= 1'b0;
      end else if (!bus.iEn) begin
         // Frozen; one-cycle strobes must not stretch or the FIFO would over-pop.
         fifo_rd_en  <= 1'b0;
         upload_done <= 1'b0;
      end else begin
         fifo_rd_en  <= 1'b0;
         upload_done <= 1'b0;
         if (bus.iFrmDone) frm_pend <= 1'b1;

         case (state)
            IDLE: begin
               wr_off <= '0;
               state  <= FETCH;
            end

            FETCH: begin
               if (!bus.iFifoEmpty) begin
                  fifo_rd_en <= 1'b1;
                  if (wr_off + BEAT_WORDS_32 > SLOT_WORDS_32) begin
                     // Slot full: pop and drop so capture is never stalled.
                     overflow <= 1'b1;
                     state    <= DISCARD;
                  end else begin
                     op_data <= bus.iFifoData;
                     op_en   <= 1'b1;
                     op_req  <= OP_WR;
                     op_addr <= slot_base + ADDR_W'(wr_off);
                     state   <= WRITE;
                  end
               end else if (frm_pend) begin
                  state <= CLOSE;
               end
            end

            WRITE: begin
               if (bus.iOpDone) begin
                  op_en  <= 1'b0;
                  wr_off <= wr_off + BEAT_WORDS_32;
                  state  <= FETCH;
               end
            end

            // Lets the pop land before the FIFO empty flag is looked at again.
            DISCARD: state <= FETCH;

            CLOSE: begin
               // A done pulse in this very cycle belongs to the next frame.
               frm_pend  <= bus.iFrmDone;
               frm_cnt   <= frm_cnt + 16'd1;
               frm_bytes <= close_bytes;
               byte_cnt  <= '0;
               rd_off    <= '0;
               if (UPLOAD_EN != 0) begin
                  if (close_bytes == '0) begin
                     upload_done <= 1'b1;
                     slot        <= next_slot(slot);
                     state       <= IDLE;
                  end else begin
                     op_en   <= 1'b1;
                     op_req  <= OP_RD;
                     op_addr <= slot_base;
                     state   <= READ;
                  end
               end else begin
                  slot  <= next_slot(slot);
                  state <= IDLE;
               end
            end

            READ: begin
               if (bus.iOpDone) begin
                  op_en     <= 1'b0;
                  shreg     <= bus.iOpRdData;
                  tx_data   <= bus.iOpRdData[DATA_W-1 -: 8];
                  tx_en     <= 1'b1;
                  beat_byte <= '0;
                  state     <= TX;
               end
            end

            TX: begin
               if (bus.iTxDone) begin
                  tx_en     <= 1'b0;
                  shreg     <= shreg << 8;
                  byte_cnt  <= byte_cnt + 32'd1;
                  beat_byte <= beat_byte + 16'd1;
                  state     <= TX_GAP;
               end
            end

            TX_GAP: begin
               if (byte_cnt >= frm_bytes) begin
                  upload_done <= 1'b1;
                  slot        <= next_slot(slot);
                  state       <= IDLE;
               end else if (beat_byte >= BEAT_BYTES_16) begin
                  rd_off  <= rd_off + BEAT_WORDS_32;
                  op_en   <= 1'b1;
                  op_req  <= OP_RD;
                  op_addr <= slot_base + ADDR_W'(rd_off + BEAT_WORDS_32);
                  state   <= READ;
               end else begin
                  tx_data <= shreg[DATA_W-1 -: 8];
                  tx_en   <= 1'b1;
                  state   <= TX;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.oFifoRdEn   = fifo_rd_en;
   assign bus.oOpEn       = op_en;
   assign bus.oOpReq      = op_req;
   assign bus.oOpAddr     = op_addr;
   assign bus.oOpData     = op_data;
   assign bus.oTxEn       = tx_en;
   assign bus.oTxData     = tx_data;
   assign bus.oSlot       = slot;
   assign bus.oFrmCnt     = frm_cnt;
   assign bus.oOverflow   = overflow;
   assign bus.oUploadDone = upload_done;

endmodule

// File: tb/tb_hyperram_frame_sequencer.sv
// Directed bench for hyperram_frame_sequencer: one instance with the default
// 2 x 2M-word ring and upload, one with 16-word slots and capture only.
module tb_hyperram_frame_sequencer;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   hyperram_frame_sequencer_if #(.DATA_W(128), .ADDR_W(23), .SLOT_W(1)) ia ();
   hyperram_frame_sequencer_if #(.DATA_W(128), .ADDR_W(23), .SLOT_W(1)) ib ();

   hyperram_frame_sequencer #(
      .DATA_W(128), .WORD_W(16), .ADDR_W(23),
      .FRAME_SLOTS(2), .SLOT_WORDS(2097152), .UPLOAD_EN(1)
   ) dut_a (.iClk(clk), .iRst(rst_a), .bus(ia));

   hyperram_frame_sequencer #(
      .DATA_W(128), .WORD_W(16), .ADDR_W(23),
      .FRAME_SLOTS(2), .SLOT_WORDS(16), .UPLOAD_EN(0)
   ) dut_b (.iClk(clk), .iRst(rst_b), .bus(ib));

   // Beat whose byte j (MSB first) is seed+j.
   function automatic logic [127:0] mk_beat(input logic [7:0] seed);
      logic [127:0] b;
      b = '0;
      for (int j = 0; j < 16; j++) b[127-8*j -: 8] = seed + 8'(j);
      return b;
   endfunction

   function automatic logic [4:0] midx(input logic [22:0] a);
      return {a[21], a[6:3]};
   endfunction

   // ---------------- instance A environment ----------------
   logic [127:0] fq_a [0:15];
   int           wp_a = 0;
   int           rp_a = 0;
   assign ia.iFifoEmpty = (wp_a == rp_a);
   assign ia.iFifoData  = fq_a[rp_a[3:0]];

   always @(posedge clk) if (ia.oFifoRdEn && (wp_a != rp_a)) rp_a <= rp_a + 1;

   int           dly_a = 0;
   int           cnt_a = 0;
   logic         done_a = 1'b0;
   logic         done_d_a = 1'b0;
   logic [127:0] rdd_a = '0;
   logic [127:0] mem_a [0:31];
   int           wr_n_a = 0;
   int           rd_n_a = 0;
   int           stab_bad_a = 0;
   int           gap_bad_a = 0;
   int           hcur_a = 0;
   int           hmax_a = 0;
   logic [22:0]  wlog_a [0:31];
   logic [127:0] dlog_a [0:31];
   logic         pen_a = 1'b0;
   logic [2:0]   preq_a = '0;
   logic [22:0]  padr_a = '0;
   logic [127:0] pdat_a = '0;
   assign ia.iOpDone   = done_a;
   assign ia.iOpRdData = rdd_a;

   always @(posedge clk) begin
      done_d_a <= done_a;
      pen_a    <= ia.oOpEn;
      preq_a   <= ia.oOpReq;
      padr_a   <= ia.oOpAddr;
      pdat_a   <= ia.oOpData;
      hcur_a   <= ia.oOpEn ? hcur_a + 1 : 0;
      if (hcur_a > hmax_a) hmax_a <= hcur_a;
      if (ia.oOpEn && pen_a &&
          ({ia.oOpReq, ia.oOpAddr, ia.oOpData} !== {preq_a, padr_a, pdat_a}))
         stab_bad_a <= stab_bad_a + 1;
      if (done_d_a && ia.oOpEn) gap_bad_a <= gap_bad_a + 1;
      if (done_a) begin
         done_a <= 1'b0;
         cnt_a  <= 0;
      end else if (ia.oOpEn) begin
         if (cnt_a >= dly_a) begin
            done_a <= 1'b1;
            if (ia.oOpReq == 3'b100) begin
               mem_a[midx(ia.oOpAddr)] <= ia.oOpData;
               wlog_a[wr_n_a[4:0]]     <= ia.oOpAddr;
               dlog_a[wr_n_a[4:0]]     <= ia.oOpData;
               wr_n_a                  <= wr_n_a + 1;
            end else begin
               rdd_a  <= mem_a[midx(ia.oOpAddr)];
               rd_n_a <= rd_n_a + 1;
            end
         end else begin
            cnt_a <= cnt_a + 1;
         end
      end else begin
         cnt_a <= 0;
      end
   end

   logic       txd_a = 1'b0;
   int         rx_n_a = 0;
   int         ud_a = 0;
   logic [7:0] rx_a [0:255];
   assign ia.iTxDone = txd_a;

   always @(posedge clk) begin
      if (ia.oUploadDone) ud_a <= ud_a + 1;
      if (txd_a) begin
         txd_a <= 1'b0;
      end else if (ia.oTxEn) begin
         txd_a              <= 1'b1;
         rx_a[rx_n_a[7:0]] <= ia.oTxData;
         rx_n_a             <= rx_n_a + 1;
      end
   end

   // ---------------- instance B environment ----------------
   logic [127:0] fq_b [0:15];
   int           wp_b = 0;
   int           rp_b = 0;
   logic         done_b = 1'b0;
   int           wr_n_b = 0;
   int           hi_b = 0;
   logic [22:0]  wlog_b [0:7];
   assign ib.iFifoEmpty = (wp_b == rp_b);
   assign ib.iFifoData  = fq_b[rp_b[3:0]];
   assign ib.iOpDone    = done_b;
   assign ib.iOpRdData  = '0;
   assign ib.iTxDone    = 1'b0;

   always @(posedge clk) begin
      if (ib.oFifoRdEn && (wp_b != rp_b)) rp_b <= rp_b + 1;
      if (done_b) begin
         done_b <= 1'b0;
      end else if (ib.oOpEn) begin
         done_b              <= 1'b1;
         wlog_b[wr_n_b[2:0]] <= ib.oOpAddr;
         wr_n_b              <= wr_n_b + 1;
         if (ib.oOpAddr >= 23'd16) hi_b <= hi_b + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [7:0] seed);
      @(negedge clk);
      fq_a[wp_a[3:0]] = mk_beat(seed);
      wp_a = wp_a + 1;
   endtask

   task automatic push_b(input logic [7:0] seed);
      @(negedge clk);
      fq_b[wp_b[3:0]] = mk_beat(seed);
      wp_b = wp_b + 1;
   endtask

   task automatic frame_a(input logic [31:0] nbytes);
      @(negedge clk);
      ia.iFrmBytes = nbytes;
      ia.iFrmDone  = 1'b1;
      @(negedge clk);
      ia.iFrmDone  = 1'b0;
   endtask

   task automatic wait_ud_a(input int target, input string tag);
      for (int n = 0; n < 6000 && ud_a < target; n++) @(negedge clk);
      chk(tag, 32'(ud_a), 32'(target));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rx0;
      ia.iEn = 1'b1; ia.iFrmDone = 1'b0; ia.iFrmBytes = '0;
      ib.iEn = 1'b1; ib.iFrmDone = 1'b0; ib.iFrmBytes = '0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_open",    32'(ia.oOpEn),       32'd0);
      chk("rst_txen",    32'(ia.oTxEn),       32'd0);
      chk("rst_rden",    32'(ia.oFifoRdEn),   32'd0);
      chk("rst_slot",    32'(ia.oSlot),       32'd0);
      chk("rst_frmcnt",  32'(ia.oFrmCnt),     32'd0);
      chk("rst_ovf",     32'(ia.oOverflow),   32'd0);
      chk("rst_updone",  32'(ia.oUploadDone), 32'd0);
      chk("rst_opaddr",  32'(ia.oOpAddr),     32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Overflow: 16-word slot takes two 8-word beats, the third is dropped.
      push_b(8'h00); push_b(8'h10); push_b(8'h20);
      @(negedge clk);
      ib.iFrmBytes = 32'd48; ib.iFrmDone = 1'b1;
      @(negedge clk);
      ib.iFrmDone = 1'b0;
      for (int n = 0; n < 300 && ib.oFrmCnt != 16'd1; n++) @(negedge clk);
      chk("ovf_frmcnt", 32'(ib.oFrmCnt),   32'd1);
      chk("ovf_writes", 32'(wr_n_b),       32'd2);
      chk("ovf_addr0",  32'(wlog_b[0]),    32'd0);
      chk("ovf_addr1",  32'(wlog_b[1]),    32'd8);
      chk("ovf_high",   32'(hi_b),         32'd0);
      chk("ovf_popped", 32'(rp_b),         32'd3);
      chk("ovf_flag",   32'(ib.oOverflow), 32'd1);
      chk("ovf_slot",   32'(ib.oSlot),     32'd1);

      // Frame 1: four beats, 64 bytes, slot 0.
      push_a(8'h00); push_a(8'h10); push_a(8'h20); push_a(8'h30);
      frame_a(32'd64);
      wait_ud_a(1, "f1_updone");
      chk("f1_writes", 32'(wr_n_a), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("f1_waddr", 32'(wlog_a[k]), 32'(8 * k));
         chk_w("f1_wdata", dlog_a[k], mk_beat(8'(16 * k)));
      end
      chk("f1_reads",  32'(rd_n_a), 32'd4);
      chk("f1_nbytes", 32'(rx_n_a), 32'd64);
      for (int k = 0; k < 64; k++) chk("f1_byte", 32'(rx_a[k]), 32'(k));
      chk("f1_frmcnt", 32'(ia.oFrmCnt), 32'd1);
      chk("f1_slot",   32'(ia.oSlot),   32'd1);

      // Frame 2: 20 bytes from two beats, slot 1.
      push_a(8'hA0); push_a(8'hB0);
      frame_a(32'd20);
      wait_ud_a(2, "f2_updone");
      chk("f2_waddr0", 32'(wlog_a[4]), 32'd2097152);
      chk("f2_waddr1", 32'(wlog_a[5]), 32'd2097160);
      chk("f2_reads",  32'(rd_n_a),    32'd6);
      chk("f2_nbytes", 32'(rx_n_a),    32'd84);
      for (int k = 0; k < 20; k++) chk("f2_byte", 32'(rx_a[64 + k]), 32'(8'hA0 + k));
      repeat (20) @(negedge clk);
      chk("f2_single_done", 32'(ud_a), 32'd2);
      chk("f2_frmcnt", 32'(ia.oFrmCnt), 32'd2);
      chk("f2_slot",   32'(ia.oSlot),   32'd0);

      // Frame 3: op engine answers after 10 cycles; ring wraps back to 0.
      dly_a = 10;
      push_a(8'h40);
      frame_a(32'd16);
      wait_ud_a(3, "f3_updone");
      chk("f3_waddr",  32'(wlog_a[6]), 32'd0);
      chk_w("f3_wdata", dlog_a[6], mk_beat(8'h40));
      chk("f3_byte0",  32'(rx_a[84]), 32'h40);
      chk("f3_byte15", 32'(rx_a[99]), 32'h4F);
      chk("f3_hold10", 32'(hmax_a >= 10), 32'd1);
      chk("f3_stable", 32'(stab_bad_a), 32'd0);
      chk("f3_gap",    32'(gap_bad_a),  32'd0);
      chk("f3_frmcnt", 32'(ia.oFrmCnt), 32'd3);
      chk("f3_slot",   32'(ia.oSlot),   32'd1);
      dly_a = 0;

      // Frame 4: zero bytes, no read, still one upload-done.
      push_a(8'h50);
      frame_a(32'd0);
      wait_ud_a(4, "f4_updone");
      chk("f4_waddr",  32'(wlog_a[7]), 32'd2097152);
      chk("f4_reads",  32'(rd_n_a),    32'd7);
      chk("f4_nbytes", 32'(rx_n_a),    32'd100);
      chk("f4_slot",   32'(ia.oSlot),  32'd0);

      // Reset while a write is outstanding.
      dly_a = 20;
      push_a(8'h60);
      for (int n = 0; n < 200 && !ia.oOpEn; n++) @(negedge clk);
      chk("rw_opstart", 32'(ia.oOpEn), 32'd1);
      @(negedge clk);
      chk("rw_fifo_drained", 32'(rp_a), 32'(wp_a));
      rst_a = 1'b1;
      #1;
      chk("rw_open",   32'(ia.oOpEn),     32'd0);
      chk("rw_rden",   32'(ia.oFifoRdEn), 32'd0);
      chk("rw_slot",   32'(ia.oSlot),     32'd0);
      chk("rw_frmcnt", 32'(ia.oFrmCnt),   32'd0);
      @(negedge clk);
      rst_a = 1'b0;
      dly_a = 0;
      push_a(8'h70);
      frame_a(32'd16);
      wait_ud_a(5, "rw_updone");
      chk("rw_waddr",  32'(wlog_a[8]), 32'd0);
      chk_w("rw_wdata", dlog_a[8], mk_beat(8'h70));
      chk("rw_byte0",  32'(rx_a[100]), 32'h70);
      chk("rw_byte15", 32'(rx_a[115]), 32'h7F);
      chk("rw_frmcnt", 32'(ia.oFrmCnt), 32'd1);
      chk("rw_slot",   32'(ia.oSlot),   32'd1);

      // Reset while a UART byte is in flight.
      push_a(8'h80);
      frame_a(32'd16);
      for (int n = 0; n < 400 && !ia.oTxEn; n++) @(negedge clk);
      chk("rt_txstart", 32'(ia.oTxEn), 32'd1);
      rst_a = 1'b1;
      #1;
      chk("rt_txen",   32'(ia.oTxEn),   32'd0);
      chk("rt_open",   32'(ia.oOpEn),   32'd0);
      chk("rt_slot",   32'(ia.oSlot),   32'd0);
      chk("rt_frmcnt", 32'(ia.oFrmCnt), 32'd0);
      @(negedge clk);
      rst_a = 1'b0;
      repeat (2) @(negedge clk);
      rx0 = rx_n_a;
      push_a(8'h90);
      frame_a(32'd16);
      wait_ud_a(6, "rt_updone");
      chk("rt_writes", 32'(wr_n_a),     32'd11);
      chk("rt_waddr",  32'(wlog_a[10]), 32'd0);
      chk_w("rt_wdata", dlog_a[10], mk_beat(8'h90));
      chk("rt_nbytes", 32'(rx_n_a - rx0), 32'd16);
      chk("rt_byte0",  32'(rx_a[rx0[7:0]]), 32'h90);
      chk("rt_byte15", 32'(rx_a[8'(rx0 + 15)]), 32'h9F);
      chk("rt_frmcnt", 32'(ia.oFrmCnt), 32'd1);
      chk("rt_slot",   32'(ia.oSlot),   32'd1);
      chk("end_stable", 32'(stab_bad_a), 32'd0);
      chk("end_gap",    32'(gap_bad_a),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
